// File: rtl/hpd_gen.sv
// Sink-side Hot Plug Detect driver: holds HPD high while connected, emits fixed-width IRQ low pulses.
// Latency: irq_req accepted at cycle t drops HPD and pulses irq_ack at t+1; HPD returns at t+1+IRQ_PULSE_TICKS.
// Backpressure: one-deep request queue; a request that cannot be held or served is reported on irq_drop.
module hpd_gen #(
   parameter int unsigned MS_TICKS          = 100,
   parameter int unsigned IRQ_PULSE_TICKS   = 75,
   parameter int unsigned IRQ_SPACING_TICKS = 200,
   parameter int unsigned UNPLUG_TICKS      = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic sink_connect,
   input  logic irq_req,
   output logic hpd_signal,
   output logic irq_ack,
   output logic irq_drop,
   output logic irq_busy,
   output logic hpd_connected
);

   // The unplug low time is never allowed to fall under one millisecond, even if
   // the integrator passes a smaller UNPLUG_TICKS; the detector would otherwise
   // see a glitch it cannot classify.
   localparam int unsigned UNPLUG_MIN = (UNPLUG_TICKS < MS_TICKS) ? MS_TICKS : UNPLUG_TICKS;

   // Terminal and "last cycle" values, sized to the 32-bit counters.
   localparam logic [31:0] UNPLUG_SAT  = 32'(UNPLUG_MIN);
   localparam logic [31:0] UNPLUG_LAST = 32'(UNPLUG_MIN - 1);
   localparam logic [31:0] SPACE_SAT   = 32'(IRQ_SPACING_TICKS);
   localparam logic [31:0] SPACE_LAST  = 32'(IRQ_SPACING_TICKS - 1);
   localparam logic [31:0] PULSE_LAST  = 32'(IRQ_PULSE_TICKS - 1);

   typedef enum logic [1:0] {
      ST_DISCONNECTED = 2'd0,
      ST_CONNECTED    = 2'd1,
      ST_IRQ_PULSE    = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [31:0] low_cnt;       // HPD-low cycles spent in DISCONNECTED
   logic [31:0] spacing_cnt;   // HPD-high cycles since entering CONNECTED
   logic [31:0] pulse_cnt;     // cycles elapsed inside the current IRQ pulse
   logic        irq_pending;   // one-deep request queue

   logic        start_pulse;   // CONNECTED -> IRQ_PULSE this cycle
   logic        pending_nxt;
   logic        drop_nxt;
   logic        spacing_ok;
   logic        pulse_done;
   logic        unplug_ok;

   assign spacing_ok = (spacing_cnt >= SPACE_LAST);
   assign pulse_done = (pulse_cnt == PULSE_LAST);
   assign unplug_ok  = (low_cnt >= UNPLUG_LAST);

   // State register; reset always returns the line to a fresh unplug wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_DISCONNECTED;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; a falling sink_connect overrides every other condition.
   always_comb begin
      next_state  = state;
      start_pulse = 1'b0;
      case (state)
         ST_DISCONNECTED: begin
            if (sink_connect && unplug_ok) begin
               next_state = ST_CONNECTED;
            end
         end
         ST_CONNECTED: begin
            if (!sink_connect) begin
               next_state = ST_DISCONNECTED;
            end else if ((irq_pending || irq_req) && spacing_ok) begin
               next_state  = ST_IRQ_PULSE;
               start_pulse = 1'b1;
            end
         end
         ST_IRQ_PULSE: begin
            if (!sink_connect) begin
               next_state = ST_DISCONNECTED;
            end else if (pulse_done) begin
               next_state = ST_CONNECTED;
            end
         end
         default: begin
            next_state = ST_DISCONNECTED;
         end
      endcase
   end

   // Request queue decode: hold, consume or drop the incoming strobe.
   always_comb begin
      pending_nxt = irq_pending;
      drop_nxt    = 1'b0;
      if ((state == ST_DISCONNECTED) || !sink_connect) begin
         // No link to signal on; anything queued is stale after a disconnect.
         pending_nxt = 1'b0;
         drop_nxt    = irq_req;
      end else if (start_pulse) begin
         // The pulse serves the queued request if there is one, so a
         // simultaneous new strobe would overflow the one-deep queue.
         pending_nxt = 1'b0;
         drop_nxt    = irq_req && irq_pending;
      end else if (irq_req) begin
         if (irq_pending) begin
            drop_nxt = 1'b1;
         end else begin
            pending_nxt = 1'b1;
         end
      end
   end

   // Saturating timers; each is cleared on entry to the state that uses it.
   always_ff @(posedge clk) begin
      if (rst) begin
         low_cnt     <= '0;
         spacing_cnt <= '0;
         pulse_cnt   <= '0;
      end else begin
         if ((state != ST_DISCONNECTED) && (next_state == ST_DISCONNECTED)) begin
            low_cnt <= '0;
         end else if ((state == ST_DISCONNECTED) && (low_cnt < UNPLUG_SAT)) begin
            low_cnt <= low_cnt + 32'd1;
         end

         if ((state != ST_CONNECTED) && (next_state == ST_CONNECTED)) begin
            spacing_cnt <= '0;
         end else if ((state == ST_CONNECTED) && (spacing_cnt < SPACE_SAT)) begin
            spacing_cnt <= spacing_cnt + 32'd1;
         end

         if (start_pulse) begin
            pulse_cnt <= '0;
         end else if ((state == ST_IRQ_PULSE) && (pulse_cnt < PULSE_LAST)) begin
            pulse_cnt <= pulse_cnt + 32'd1;
         end
      end
   end

   // Registered outputs, derived from the upcoming state so they track it exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_pending   <= 1'b0;
         hpd_signal    <= 1'b0;
         irq_ack       <= 1'b0;
         irq_drop      <= 1'b0;
         irq_busy      <= 1'b0;
         hpd_connected <= 1'b0;
      end else begin
         irq_pending   <= pending_nxt;
         hpd_signal    <= (next_state == ST_CONNECTED);
         irq_ack       <= start_pulse;
         irq_drop      <= drop_nxt;
         irq_busy      <= pending_nxt || (next_state == ST_IRQ_PULSE);
         hpd_connected <= (next_state != ST_DISCONNECTED);
      end
   end

endmodule

// File: tb/tb_hpd_gen.sv
// Directed bench for hpd_gen: countdown-based reference model compared every cycle,
// plus hand-computed timing checks for unplug, spacing, pulse width and drops.
module tb_hpd_gen;

   localparam int UNPLUG  = 200;
   localparam int SPACING = 200;
   localparam int PULSE   = 75;

   logic clk = 1'b0;
   logic rst;
   logic sink_connect;
   logic irq_req;
   logic hpd_signal;
   logic irq_ack;
   logic irq_drop;
   logic irq_busy;
   logic hpd_connected;

   always #5 clk = ~clk;

   hpd_gen #(
      .MS_TICKS         (100),
      .IRQ_PULSE_TICKS  (PULSE),
      .IRQ_SPACING_TICKS(SPACING),
      .UNPLUG_TICKS     (UNPLUG)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sink_connect (sink_connect),
      .irq_req      (irq_req),
      .hpd_signal   (hpd_signal),
      .irq_ack      (irq_ack),
      .irq_drop     (irq_drop),
      .irq_busy     (irq_busy),
      .hpd_connected(hpd_connected)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks "cycles still to wait" for each rule.
   bit m_valid = 1'b0;
   bit m_conn, m_pulse, m_pend;
   bit m_ack, m_drop;
   int unplug_left, spacing_left, pulse_left;

   task automatic model_step();
      m_ack  = 1'b0;
      m_drop = 1'b0;
      if (rst) begin
         m_conn = 0; m_pulse = 0; m_pend = 0;
         unplug_left = UNPLUG; spacing_left = SPACING; pulse_left = 0;
      end else if (!m_conn) begin
         m_drop = irq_req;
         if (sink_connect && unplug_left <= 1) begin
            m_conn = 1; spacing_left = SPACING;
         end else if (unplug_left > 0) begin
            unplug_left--;
         end
      end else if (!sink_connect) begin
         m_drop = irq_req;
         m_conn = 0; m_pulse = 0; m_pend = 0; unplug_left = UNPLUG;
      end else if (m_pulse) begin
         if (irq_req) begin
            if (m_pend) m_drop = 1; else m_pend = 1;
         end
         pulse_left--;
         if (pulse_left == 0) begin
            m_pulse = 0; spacing_left = SPACING;
         end
      end else begin
         if ((m_pend || irq_req) && spacing_left <= 1) begin
            m_drop = irq_req && m_pend;
            m_pend = 0; m_pulse = 1; pulse_left = PULSE; m_ack = 1;
         end else begin
            if (irq_req) begin
               if (m_pend) m_drop = 1; else m_pend = 1;
            end
            if (spacing_left > 0) spacing_left--;
         end
      end
      m_valid = 1'b1;
   endtask

   // Advance the model on every active edge, using the same sampled inputs as the DUT.
   always @(posedge clk) model_step();

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("hpd_signal",    hpd_signal,    m_conn && !m_pulse);
         check("irq_ack",       irq_ack,       m_ack);
         check("irq_drop",      irq_drop,      m_drop);
         check("irq_busy",      irq_busy,      m_pend || m_pulse);
         check("hpd_connected", hpd_connected, m_conn);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts falling edges until hpd_signal reaches lvl; bounded so it always ends.
   task automatic wait_level(input logic lvl, input int exp_n, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (hpd_signal !== lvl && n < exp_n + 50);
      check(name, n, exp_n);
   endtask

   initial begin
      rst = 1'b1; sink_connect = 1'b1; irq_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hpd", hpd_signal, 0);
      check("rst_busy", irq_busy, 0);
      check("rst_connected", hpd_connected, 0);
      rst = 1'b0;

      // Unplug wait from reset, then HPD rises.
      wait_level(1'b1, UNPLUG, "unplug_rise");
      check("rise_connected", hpd_connected, 1);

      // Early request is held until spacing is met.
      step(50);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      check("early_req_busy", irq_busy, 1);
      wait_level(1'b0, SPACING - 51, "spacing_hold");
      check("spacing_ack", irq_ack, 1);
      wait_level(1'b1, PULSE, "pulse_width");

      // Immediate request with spacing satisfied, then queue and overflow.
      step(300);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      check("imm_hpd_low", hpd_signal, 0);
      check("imm_ack", irq_ack, 1);
      check("imm_busy", irq_busy, 1);
      step(1);
      check("imm_ack_once", irq_ack, 0);
      step(8);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      step(9);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      check("overflow_drop", irq_drop, 1);
      wait_level(1'b1, PULSE - 20, "pulse2_end");
      check("queued_busy", irq_busy, 1);
      wait_level(1'b0, SPACING, "queued_fire");
      check("queued_ack", irq_ack, 1);

      // Disconnect at pulse cycle 30 with a request pending, immediate replug.
      step(8);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      step(19);
      sink_connect = 1'b0; step(1); sink_connect = 1'b1;
      check("disc_hpd", hpd_signal, 0);
      check("disc_busy", irq_busy, 0);
      check("disc_connected", hpd_connected, 0);
      wait_level(1'b1, UNPLUG, "reconnect_rise");

      // Request coincident with disconnect, then request while disconnected.
      step(5);
      sink_connect = 1'b0; irq_req = 1'b1; step(1); irq_req = 1'b0;
      check("coinc_drop", irq_drop, 1);
      check("coinc_ack", irq_ack, 0);
      check("coinc_hpd", hpd_signal, 0);
      step(5);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      check("disc_req_drop", irq_drop, 1);
      check("disc_req_ack", irq_ack, 0);
      step(1);
      check("disc_drop_once", irq_drop, 0);
      sink_connect = 1'b1;
      wait_level(1'b1, UNPLUG - 7, "replug_rise");

      // Reset in the middle of a pulse restarts the unplug wait.
      step(250);
      irq_req = 1'b1; step(1); irq_req = 1'b0;
      check("pre_rst_hpd", hpd_signal, 0);
      step(10);
      rst = 1'b1; step(1);
      check("midrst_hpd", hpd_signal, 0);
      check("midrst_busy", irq_busy, 0);
      check("midrst_connected", hpd_connected, 0);
      rst = 1'b0;
      wait_level(1'b1, UNPLUG, "midrst_rise");
      step(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
